// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory responder with configurable wait states
// and a one-cycle ready pulse for the multicycle CPU's shared memory port.
module mem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                w_req;
  logic                w_illegal;
  logic                w_accept;
  logic                w_access;
  logic                w_acc_write;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;

  assign w_req     = mem_read | mem_write;
  assign w_illegal = mem_read & mem_write;
  assign w_accept  = (r_state == S_IDLE) && w_req;

  // With zero wait states the access happens at the accepting edge, so it
  // must use the live inputs rather than the registers being loaded there.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_access    = 1'b0;
    w_acc_write = r_is_write;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_illegal) begin
            w_next = S_DONE;
          end else if (WAIT == 0) begin
            w_next      = S_DONE;
            w_access    = 1'b1;
            w_acc_write = mem_write;
            w_acc_addr  = addr;
            w_acc_wdata = wdata;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LP_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_DONE;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_is_write <= mem_write;
        r_err      <= w_illegal;
      end else if (r_state == S_DONE) begin
        r_err <= 1'b0;
      end
      if (w_access && !w_acc_write) begin
        r_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  // Array is not reset; a write is blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && w_access && w_acc_write) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = (r_state == S_DONE);
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// using three instances (WAIT=2, WAIT=0, WAIT=3).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstn [3];
  logic        mr   [3];
  logic        mw   [3];
  logic [8:0]  ad   [3];
  logic [31:0] wd   [3];
  wire  [31:0] rd   [3];
  wire         rdy  [3];
  wire         bsy  [3];
  wire         er   [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT(2)) u_w2 (
    .clk(clk), .rst(rstn[0]), .mem_read(mr[0]), .mem_write(mw[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]),
    .busy(bsy[0]), .err(er[0]));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rstn[1]), .mem_read(mr[1]), .mem_write(mw[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]),
    .busy(bsy[1]), .err(er[1]));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rstn[2]), .mem_read(mr[2]), .mem_write(mw[2]),
    .addr(ad[2]), .wdata(wd[2]), .rdata(rd[2]), .ready(rdy[2]),
    .busy(bsy[2]), .err(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: drive at a negedge, wait for ready, optionally keep the
  // request asserted for back-to-back use, optionally perturb addr/wdata
  // right after acceptance.
  task automatic op(input int k, input logic r, input logic w,
                    input logic [8:0] a, input logic [31:0] d,
                    input int elat, input bit hold,
                    input bit pert, input logic [8:0] pa, input logic [31:0] pd,
                    output logic [31:0] rv, output logic ev, output int bcnt);
    int  lat;
    bit  seen;
    @(negedge clk);
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    lat = 0; bcnt = 0; seen = 1'b0;
    if (pert) begin
      @(posedge clk);
      #1;
      ad[k] = pa; wd[k] = pd;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (bsy[k]) bcnt++;
      if (rdy[k]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    rv = rd[k];
    ev = er[k];
    if (!hold) begin
      @(posedge clk);
      #1;
      mr[k] = 1'b0; mw[k] = 1'b0;
      @(negedge clk);
      chk("post_busy", 32'(bsy[k]), 32'd0);
      chk("post_ready", 32'(rdy[k]), 32'd0);
      chk("post_err", 32'(er[k]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic        ev;
    int          bc;

    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_err", 32'(er[k]), 32'd0);
      chk("rst_rdata", rd[k], 32'h0);
    end
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

    // 1: WAIT=2 write then read of addr 5
    op(0, 1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t1_wr_rdata", rv, 32'h0);
    chk("t1_wr_err", 32'(ev), 32'd0);
    chk("t1_busy_cycles", 32'(bc), 32'd3);
    op(0, 1'b1, 1'b0, 9'd5, 32'h0, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t1_rd_data", rv, 32'hDEADBEEF);
    chk("t1_rd_err", 32'(ev), 32'd0);

    // 2: WAIT=0 back-to-back writes 0,1,2 then reads 2,1,0 with request held
    op(1, 1'b0, 1'b1, 9'd0, 32'h1000_0000, 1, 1'b1, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(1, 1'b0, 1'b1, 9'd1, 32'h1000_0001, 1, 1'b1, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(1, 1'b0, 1'b1, 9'd2, 32'h1000_0002, 1, 1'b1, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t2_wr_rdata", rv, 32'h0);
    op(1, 1'b1, 1'b0, 9'd2, 32'h0, 1, 1'b1, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t2_rd2", rv, 32'h1000_0002);
    op(1, 1'b1, 1'b0, 9'd1, 32'h0, 1, 1'b1, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t2_rd1", rv, 32'h1000_0001);
    op(1, 1'b1, 1'b0, 9'd0, 32'h0, 1, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t2_rd0", rv, 32'h1000_0000);

    // 3: illegal read+write on addr 7 leaves contents and rdata untouched
    op(1, 1'b0, 1'b1, 9'd7, 32'hCAFE0007, 1, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(1, 1'b1, 1'b1, 9'd7, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t3_err", 32'(ev), 32'd1);
    chk("t3_rdata_kept", rv, 32'h1000_0000);
    op(1, 1'b1, 1'b0, 9'd7, 32'h0, 1, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t3_rd7", rv, 32'hCAFE0007);
    chk("t3_rd7_err", 32'(ev), 32'd0);

    // 4: WAIT=3 write abandoned by reset one cycle after acceptance
    op(2, 1'b0, 1'b1, 9'd9, 32'h0, 4, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    @(negedge clk);
    mw[2] = 1'b1; ad[2] = 9'd9; wd[2] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t4_busy_before", 32'(bsy[2]), 32'd1);
    rstn[2] = 1'b0;
    #1;
    chk("t4_busy_rst", 32'(bsy[2]), 32'd0);
    chk("t4_ready_rst", 32'(rdy[2]), 32'd0);
    mw[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_ready_hold", 32'(rdy[2]), 32'd0);
    rstn[2] = 1'b1;
    op(2, 1'b1, 1'b0, 9'd9, 32'h0, 4, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t4_rd9", rv, 32'h0);

    // 5: top address vs address 0 on WAIT=2
    op(0, 1'b0, 1'b1, 9'd0, 32'h0000_1111, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(0, 1'b0, 1'b1, 9'd511, 32'hA5A5A5A5, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(0, 1'b1, 1'b0, 9'd511, 32'h0, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t5_rd511", rv, 32'hA5A5A5A5);
    op(0, 1'b1, 1'b0, 9'd0, 32'h0, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t5_rd0", rv, 32'h0000_1111);

    // 6: addr/wdata changed during WAIT have no effect
    op(0, 1'b0, 1'b1, 9'd21, 32'h2121_2121, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    op(0, 1'b0, 1'b1, 9'd20, 32'h2020_2020, 3, 1'b0, 1'b1, 9'd21, 32'hBADB_AD00, rv, ev, bc);
    op(0, 1'b1, 1'b0, 9'd20, 32'h0, 3, 1'b0, 1'b0, 9'd0, 32'h0, rv, ev, bc);
    chk("t6_rd20", rv, 32'h2020_2020);
    op(0, 1'b1, 1'b0, 9'd21, 32'h0, 3, 1'b0, 1'b1, 9'd5, 32'h0, rv, ev, bc);
    chk("t6_rd21", rv, 32'h2121_2121);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
